// File: rtl/aes_pkg.sv
// Shared AES definitions: block/word/round-key types, forward and inverse S-boxes,
// GF(2^8) helpers and the inverse-cipher FSM state encoding.
package aes_pkg;

  localparam int BLOCK_W = 128;

  typedef logic [BLOCK_W-1:0] block_t;
  typedef logic [31:0]        word_t;
  typedef logic [BLOCK_W-1:0] round_key_t;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    DONE
  } inv_fsm_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Shift-and-add multiply in GF(2^8); b is always a small constant at the call sites.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES decryption round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless this is the final round.
module aes_inv_round
  import aes_pkg::*;
(
  input  block_t     i_state,
  input  round_key_t i_round_key,
  input  logic       i_last,
  output block_t     o_state
);

  function automatic word_t inv_mix_col(input word_t c);
    logic [7:0] s0, s1, s2, s3;
    {s0, s1, s2, s3} = c;
    return {gmul(s0, 8'h0e) ^ gmul(s1, 8'h0b) ^ gmul(s2, 8'h0d) ^ gmul(s3, 8'h09),
            gmul(s0, 8'h09) ^ gmul(s1, 8'h0e) ^ gmul(s2, 8'h0b) ^ gmul(s3, 8'h0d),
            gmul(s0, 8'h0d) ^ gmul(s1, 8'h09) ^ gmul(s2, 8'h0e) ^ gmul(s3, 8'h0b),
            gmul(s0, 8'h0b) ^ gmul(s1, 8'h0d) ^ gmul(s2, 8'h09) ^ gmul(s3, 8'h0e)};
  endfunction

  block_t shifted;
  block_t subbed;
  block_t keyed;
  block_t mixed;

  // Byte 4*c+r is row r of column c; row r rotates right by r columns.
  always_comb begin
    shifted = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shifted[BLOCK_W-1-8*(4*c+r) -: 8] = i_state[BLOCK_W-1-8*(4*((c-r+4)%4)+r) -: 8];
      end
    end
  end

  always_comb begin
    subbed = '0;
    for (int i = 0; i < 16; i++) begin
      subbed[BLOCK_W-1-8*i -: 8] = INV_SBOX[shifted[BLOCK_W-1-8*i -: 8]];
    end
  end

  assign keyed = subbed ^ i_round_key;

  always_comb begin
    mixed = '0;
    for (int c = 0; c < 4; c++) begin
      mixed[BLOCK_W-1-32*c -: 32] = inv_mix_col(keyed[BLOCK_W-1-32*c -: 32]);
    end
  end

  assign o_state = i_last ? keyed : mixed;

endmodule

// File: rtl/aes_inv_cipher.sv
// Iterative AES inverse cipher, one round per clock, AXI4-Stream in/out.
// Define AES_INV_SIDEBAND_EN to carry tlast/tstrb alongside each block.
module aes_inv_cipher
  import aes_pkg::*;
#(
  parameter int WORD = 32,
  parameter int NB   = 4,
  parameter int NR   = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [(NR+1)*WORD*NB-1:0]   i_round_keys,
  input  logic                        i_axi4s_tvalid,
  output logic                        o_axi4s_tready,
  input  logic [WORD*NB-1:0]          i_axi4s_tdata,
`ifdef AES_INV_SIDEBAND_EN
  input  logic                        i_axi4s_tlast,
  input  logic [WORD*NB/8-1:0]        i_axi4s_tstrb,
  output logic                        o_axi4s_tlast,
  output logic [WORD*NB/8-1:0]        o_axi4s_tstrb,
`endif
  output logic                        o_axi4s_tvalid,
  input  logic                        i_axi4s_tready,
  output logic [WORD*NB-1:0]          o_axi4s_tdata
);

  localparam int BW    = WORD * NB;
  localparam int CNT_W = (NR > 1) ? $clog2(NR) : 1;

  inv_fsm_e         fsm_q, fsm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BW-1:0]    state_q, state_d;
  block_t           round_key;
  block_t           round_out;
`ifdef AES_INV_SIDEBAND_EN
  logic             tlast_q, tlast_d;
  logic [BW/8-1:0]  tstrb_q, tstrb_d;
`endif

  assign round_key = i_round_keys[int'(cnt_q)*BW +: BW];

  aes_inv_round u_round (
    .i_state     (state_q),
    .i_round_key (round_key),
    .i_last      (cnt_q == '0),
    .o_state     (round_out)
  );

  always_comb begin
    fsm_d   = fsm_q;
    cnt_d   = cnt_q;
    state_d = state_q;
`ifdef AES_INV_SIDEBAND_EN
    tlast_d = tlast_q;
    tstrb_d = tstrb_q;
`endif
    case (fsm_q)
      IDLE: begin
        if (i_axi4s_tvalid) begin
          state_d = i_axi4s_tdata ^ i_round_keys[NR*BW +: BW];
          cnt_d   = CNT_W'(NR - 1);
          fsm_d   = ROUND;
`ifdef AES_INV_SIDEBAND_EN
          tlast_d = i_axi4s_tlast;
          tstrb_d = i_axi4s_tstrb;
`endif
        end
      end
      ROUND: begin
        state_d = round_out;
        // The counter parks at zero on the final round rather than wrapping.
        if (cnt_q == '0) fsm_d = DONE;
        else             cnt_d = cnt_q - CNT_W'(1);
      end
      DONE: begin
        if (i_axi4s_tready) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= IDLE;
      cnt_q   <= '0;
      state_q <= '0;
`ifdef AES_INV_SIDEBAND_EN
      tlast_q <= 1'b0;
      tstrb_q <= '0;
`endif
    end else begin
      fsm_q   <= fsm_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
`ifdef AES_INV_SIDEBAND_EN
      tlast_q <= tlast_d;
      tstrb_q <= tstrb_d;
`endif
    end
  end

  assign o_axi4s_tready = (fsm_q == IDLE);
  assign o_axi4s_tvalid = (fsm_q == DONE);
  assign o_axi4s_tdata  = state_q;
`ifdef AES_INV_SIDEBAND_EN
  assign o_axi4s_tlast  = tlast_q;
  assign o_axi4s_tstrb  = tstrb_q;
`endif

endmodule

// File: tb/tb_aes_inv_cipher.sv
// Directed bench for aes_inv_cipher: FIPS-197 vectors for NR=10 and NR=14, latency,
// backpressure, back-to-back throughput, reset behaviour and the optional sideband.
module tb_aes_inv_cipher;

  localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_C3 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;

  logic           clk = 1'b0;
  logic           rst;
  logic [1407:0]  keys10;
  logic [1919:0]  keys14;
  logic           in_valid, out_ready, dut_ready, dut_valid;
  logic [127:0]   in_data, dut_data;
  logic           in_valid14, out_ready14, dut14_ready, dut14_valid;
  logic [127:0]   in_data14, dut14_data;
`ifdef AES_INV_SIDEBAND_EN
  logic           in_last, dut_last, in_last14, dut14_last;
  logic [15:0]    in_strb, dut_strb, in_strb14, dut14_strb;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  aes_inv_cipher #(.WORD(32), .NB(4), .NR(10)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_round_keys   (keys10),
    .i_axi4s_tvalid (in_valid),
    .o_axi4s_tready (dut_ready),
    .i_axi4s_tdata  (in_data),
`ifdef AES_INV_SIDEBAND_EN
    .i_axi4s_tlast  (in_last),
    .i_axi4s_tstrb  (in_strb),
    .o_axi4s_tlast  (dut_last),
    .o_axi4s_tstrb  (dut_strb),
`endif
    .o_axi4s_tvalid (dut_valid),
    .i_axi4s_tready (out_ready),
    .o_axi4s_tdata  (dut_data)
  );

  aes_inv_cipher #(.WORD(32), .NB(4), .NR(14)) dut14 (
    .clk            (clk),
    .rst            (rst),
    .i_round_keys   (keys14),
    .i_axi4s_tvalid (in_valid14),
    .o_axi4s_tready (dut14_ready),
    .i_axi4s_tdata  (in_data14),
`ifdef AES_INV_SIDEBAND_EN
    .i_axi4s_tlast  (in_last14),
    .i_axi4s_tstrb  (in_strb14),
    .o_axi4s_tlast  (dut14_last),
    .o_axi4s_tstrb  (dut14_strb),
`endif
    .o_axi4s_tvalid (dut14_valid),
    .i_axi4s_tready (out_ready14),
    .o_axi4s_tdata  (dut14_data)
  );

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {aes_pkg::SBOX[w[31:24]], aes_pkg::SBOX[w[23:16]],
            aes_pkg::SBOX[w[15:8]],  aes_pkg::SBOX[w[7:0]]};
  endfunction

  // Standard FIPS-197 key expansion; round key r lands at bits [r*128 +: 128].
  function automatic logic [1919:0] expand_key(input logic [255:0] key, input int nk, input int nr);
    logic [31:0]   w [60];
    logic [31:0]   temp;
    logic [7:0]    rcon;
    logic [1919:0] rks;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    rcon = 8'h01;
    for (int i = nk; i < 4*(nr+1); i++) begin
      temp = w[i-1];
      if (i % nk == 0) begin
        temp = sub_word({temp[23:0], temp[31:24]}) ^ {rcon, 24'h000000};
        rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
      end else if (nk > 6 && i % nk == 4) begin
        temp = sub_word(temp);
      end
      w[i] = w[i-nk] ^ temp;
    end
    rks = '0;
    for (int r = 0; r <= nr; r++) rks[r*128 +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return rks;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Present one block for a single handshake, then count edges until tvalid.
  task automatic applyStimulus(input bit wide, input logic [127:0] ct, output int lat);
    if (wide) begin in_valid14 = 1'b1; in_data14 = ct; end
    else      begin in_valid   = 1'b1; in_data   = ct; end
    @(negedge clk);
    in_valid   = 1'b0;
    in_valid14 = 1'b0;
    lat = 1;
    while (!(wide ? dut14_valid : dut_valid) && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic popOutput(input bit wide);
    if (wide) out_ready14 = 1'b1;
    else      out_ready   = 1'b1;
    @(negedge clk);
    out_ready   = 1'b0;
    out_ready14 = 1'b0;
  endtask

  task automatic watchIdle(input int n, output int seen);
    seen = 0;
    repeat (n) begin
      @(negedge clk);
      if (dut_valid) seen++;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [1919:0] tmp;
    logic [1407:0] rk_c1, rk_b;
    int lat, seen, bad, cyc;
    int t[$];

    tmp    = expand_key({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, 10);
    rk_c1  = tmp[1407:0];
    tmp    = expand_key({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4, 10);
    rk_b   = tmp[1407:0];
    keys14 = expand_key(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14);
    keys10 = rk_c1;

    rst = 1'b1;
    in_valid = 1'b0;   in_data = '0;   out_ready = 1'b0;
    in_valid14 = 1'b0; in_data14 = '0; out_ready14 = 1'b0;
`ifdef AES_INV_SIDEBAND_EN
    in_last = 1'b0; in_strb = '0; in_last14 = 1'b0; in_strb14 = '0;
`endif
    repeat (2) @(negedge clk);
    checkOutput("rst_tvalid",   128'(dut_valid),   128'd0);
    checkOutput("rst_tdata",    dut_data,          128'd0);
    checkOutput("rst_tready",   128'(dut_ready),   128'd1);
    checkOutput("rst_tvalid14", 128'(dut14_valid), 128'd0);
    checkOutput("rst_tready14", 128'(dut14_ready), 128'd1);
`ifdef AES_INV_SIDEBAND_EN
    checkOutput("rst_tlast",    128'(dut_last),    128'd0);
    checkOutput("rst_tstrb",    128'(dut_strb),    128'd0);
    checkOutput("rst_tlast14",  128'(dut14_last),  128'd0);
    checkOutput("rst_tstrb14",  128'(dut14_strb),  128'd0);
`endif
    rst = 1'b0;

    $display("[TB] FIPS-197 C.1 single block");
`ifdef AES_INV_SIDEBAND_EN
    in_last = 1'b1; in_strb = 16'h00ff;
`endif
    applyStimulus(1'b0, CT_C1, lat);
`ifdef AES_INV_SIDEBAND_EN
    in_last = 1'b0; in_strb = 16'h0000;
    checkOutput("sb_tlast", 128'(dut_last), 128'd1);
    checkOutput("sb_tstrb", 128'(dut_strb), 128'h00ff);
`endif
    checkOutput("c1_latency", 128'(lat), 128'd11);
    checkOutput("c1_tvalid",  128'(dut_valid), 128'd1);
    checkOutput("c1_tdata",   dut_data, PT_C);

    $display("[TB] backpressure with a second block offered");
    bad = 0;
    in_valid = 1'b1;
    in_data  = CT_B;
    repeat (20) begin
      @(negedge clk);
      if (dut_valid !== 1'b1 || dut_data !== PT_C || dut_ready !== 1'b0) bad++;
    end
    in_valid = 1'b0;
    checkOutput("bp_unstable_cycles", 128'(bad), 128'd0);
    popOutput(1'b0);
    checkOutput("bp_pop_tvalid", 128'(dut_valid), 128'd0);
    checkOutput("bp_pop_tready", 128'(dut_ready), 128'd1);
    watchIdle(15, seen);
    checkOutput("bp_second_ignored", 128'(seen), 128'd0);

    $display("[TB] FIPS-197 appendix B vector");
    keys10 = rk_b;
    applyStimulus(1'b0, CT_B, lat);
    checkOutput("b_latency", 128'(lat), 128'd11);
    checkOutput("b_tdata",   dut_data, PT_B);
    popOutput(1'b0);
    keys10 = rk_c1;

    $display("[TB] back-to-back blocks");
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = CT_C1;
    cyc = 0;
    bad = 0;
    while (t.size() < 3 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (dut_valid) begin
        t.push_back(cyc);
        if (dut_data !== PT_C) bad++;
        if (t.size() == 3) in_valid = 1'b0;
      end
    end
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("b2b_count",    128'(t.size()), 128'd3);
    checkOutput("b2b_data_bad", 128'(bad), 128'd0);
    checkOutput("b2b_first",    128'((t.size() > 0) ? t[0] : -1), 128'd11);
    checkOutput("b2b_gap1",     128'((t.size() > 1) ? t[1] - t[0] : -1), 128'd12);
    checkOutput("b2b_gap2",     128'((t.size() > 2) ? t[2] - t[1] : -1), 128'd12);
    watchIdle(15, seen);
    checkOutput("b2b_no_extra", 128'(seen), 128'd0);

    $display("[TB] reset during round 5");
    in_valid = 1'b1;
    in_data  = CT_C1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_tvalid", 128'(dut_valid), 128'd0);
    checkOutput("midrst_tdata",  dut_data, 128'd0);
    rst = 1'b0;
    checkOutput("midrst_tready", 128'(dut_ready), 128'd1);
    watchIdle(15, seen);
    checkOutput("midrst_no_output", 128'(seen), 128'd0);

    $display("[TB] reset wins over a simultaneous handshake");
    rst = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    checkOutput("rstprio_tready", 128'(dut_ready), 128'd1);
    watchIdle(15, seen);
    checkOutput("rstprio_no_output", 128'(seen), 128'd0);

    applyStimulus(1'b0, CT_C1, lat);
    checkOutput("recover_latency", 128'(lat), 128'd11);
    checkOutput("recover_tdata",   dut_data, PT_C);
    popOutput(1'b0);

    $display("[TB] FIPS-197 C.3 with NR=14");
    applyStimulus(1'b1, CT_C3, lat);
    checkOutput("c3_latency", 128'(lat), 128'd15);
    checkOutput("c3_tvalid",  128'(dut14_valid), 128'd1);
    checkOutput("c3_tdata",   dut14_data, PT_C);
    popOutput(1'b1);
    checkOutput("c3_pop_tvalid", 128'(dut14_valid), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
